// File: rtl/sdram_fill_sequencer_pkg.sv
// Shared definitions for the SDRAM line-fill sequencer.
//   fill_state_e : sequencer state (idle, request, collect, stream)
//   LINE_WORDS   : words per cache line / per burst
//   WORD_W       : data word width
//   IDX_W        : width of a word index within a line
package sdram_fill_sequencer_pkg;

    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StCollect,
        StStream
    } fill_state_e;

endpackage

// File: rtl/fill_line_buffer.sv
// Eight-entry line buffer for the fill sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : drop all per-entry valid bits (start of a new line)
//   wr_en/wr_idx/wr_data : write port, sets the entry's valid bit
//   rd_en/rd_idx         : registered read request
//   rd_hit     : requested entry is valid now (or being written this cycle)
//   rd_data    : registered read data; holds its old value on a miss
module fill_line_buffer
    import sdram_fill_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_hit,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0]     mem_q [LINE_WORDS];
    logic [LINE_WORDS-1:0] vld_q;
    logic                  fwd;

    // A word arriving in the same cycle it is due is forwarded, not counted as missing.
    assign fwd    = wr_en && (wr_idx == rd_idx);
    assign rd_hit = vld_q[rd_idx] || fwd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            rd_data <= '0;
        end else begin
            if (clear) begin
                vld_q <= '0;
            end else if (wr_en) begin
                vld_q[wr_idx] <= 1'b1;
            end
            if (rd_en && rd_hit) begin
                rd_data <= fwd ? wr_data : mem_q[rd_idx];
            end
        end
    end

    // Storage needs no reset: valid bits gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/sdram_fill_sequencer.sv
// Line-fill sequencer between the cache fill port and the SDRAM burst-read port.
// Latches a fill request, issues one 8-word critical-word-first burst, buffers the
// (possibly gappy) returned words and replays them as an unbroken 8-cycle stream.
//   clk, reset          : clock, asynchronous active-high reset
//   cache_req/cache_addr: fill request and word address of the missed word
//   cache_fill          : one-cycle pulse with the first (critical) word on cache_data
//   cache_data          : registered fill data stream
//   sdr_req/sdr_addr    : burst request, held until sdr_ack
//   sdr_ack             : controller accepted the burst
//   sdr_valid/sdr_data  : returned burst words in wrap order
//   busy                : request latched until last streamed word
//   underrun            : sticky, a due word had not arrived
//   timeout             : sticky, sdr_ack not seen within REQ_TIMEOUT cycles
module sdram_fill_sequencer
    import sdram_fill_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned START_LEVEL = 8,
    parameter int unsigned REQ_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cache_req,
    input  logic [ADDR_W-1:0] cache_addr,
    output logic              cache_fill,
    output logic [WORD_W-1:0] cache_data,
    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic              sdr_valid,
    input  logic [WORD_W-1:0] sdr_data,
    output logic              busy,
    output logic              underrun,
    output logic              timeout
);

    localparam int unsigned     TO_W      = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT + 1) : 1;
    // With REQ_TIMEOUT = 0 the counter max is 0, so it never advances and never flags.
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(REQ_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(REQ_TIMEOUT - 1);
    localparam logic [3:0]      START_CNT = 4'(START_LEVEL);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sdr_req_q, sdr_req_d;
    logic              busy_q, busy_d;
    logic              fill_q, fill_d;
    logic              underrun_q, underrun_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              wr_done_q, wr_done_d;
    logic [3:0]        rd_cnt_q, rd_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              wr_accept;
    logic [3:0]        fill_count;
    logic              stream_start;
    logic              stream_step;
    logic              stream_end;
    logic              start_req;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_hit;

    // Words count from the ack cycle on; anything past the eighth, or while idle, is dropped.
    assign wr_accept = sdr_valid && !wr_done_q &&
                       ((state_q == StReq && sdr_ack) ||
                        state_q == StCollect || state_q == StStream);
    assign fill_count = {wr_done_q, wr_cnt_q} + 4'(wr_accept);

    // Start decision includes this cycle's word so the fill follows the last word directly.
    assign stream_start = (state_q == StCollect) && (fill_count >= START_CNT);
    assign stream_step  = (state_q == StStream) && !rd_cnt_q[3];
    assign stream_end   = (state_q == StStream) && rd_cnt_q[3];
    assign start_req    = cache_req && ((state_q == StIdle) || stream_end);

    assign rd_en  = stream_start || stream_step;
    assign rd_idx = stream_step ? rd_cnt_q[IDX_W-1:0] : '0;

    fill_line_buffer u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_req),
        .wr_en   (wr_accept),
        .wr_idx  (wr_cnt_q),
        .wr_data (sdr_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_hit  (rd_hit),
        .rd_data (cache_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sdr_req_d  = sdr_req_q;
        busy_d     = busy_q;
        fill_d     = 1'b0;
        underrun_d = underrun_q;
        timeout_d  = timeout_q;
        wr_cnt_d   = wr_cnt_q;
        wr_done_d  = wr_done_q;
        rd_cnt_d   = rd_cnt_q;
        to_cnt_d   = to_cnt_q;

        if (wr_accept) begin
            wr_done_d = fill_count[3];
            wr_cnt_d  = fill_count[IDX_W-1:0];
        end

        case (state_q)
            StReq: begin
                if (sdr_ack) begin
                    sdr_req_d = 1'b0;
                    state_d   = StCollect;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                if (stream_start) begin
                    state_d  = StStream;
                    fill_d   = 1'b1;
                    rd_cnt_d = 4'd1;
                end
            end
            StStream: begin
                if (stream_step) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
                if (stream_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase

        // The cache consumes every cycle, so a missing word repeats the previous one.
        if (rd_en && !rd_hit) begin
            underrun_d = 1'b1;
        end

        // A held cache_req at the end of a stream chains straight into the next burst.
        if (start_req) begin
            state_d   = StReq;
            addr_d    = cache_addr;
            sdr_req_d = 1'b1;
            busy_d    = 1'b1;
            wr_cnt_d  = '0;
            wr_done_d = 1'b0;
            to_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            sdr_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            fill_q     <= 1'b0;
            underrun_q <= 1'b0;
            timeout_q  <= 1'b0;
            wr_cnt_q   <= '0;
            wr_done_q  <= 1'b0;
            rd_cnt_q   <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sdr_req_q  <= sdr_req_d;
            busy_q     <= busy_d;
            fill_q     <= fill_d;
            underrun_q <= underrun_d;
            timeout_q  <= timeout_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_done_q  <= wr_done_d;
            rd_cnt_q   <= rd_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign cache_fill = fill_q;
    assign sdr_req    = sdr_req_q;
    assign sdr_addr   = addr_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sdram_fill_sequencer.sv
// Directed bench for sdram_fill_sequencer. Two instances share stimulus:
// u_dut_a (START_LEVEL=8) and u_dut_b (START_LEVEL=2), both with REQ_TIMEOUT=10.
// Expected stream words are queued as stimulus is driven and popped as the
// selected instance streams them.
module tb_sdram_fill_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_req;
    logic [24:0] cache_addr;
    logic        sdr_ack;
    logic        sdr_valid;
    logic [15:0] sdr_data;

    logic        cache_fill_a, sdr_req_a, busy_a, underrun_a, timeout_a;
    logic [15:0] cache_data_a;
    logic [24:0] sdr_addr_a;
    logic        cache_fill_b, sdr_req_b, busy_b, underrun_b, timeout_b;
    logic [15:0] cache_data_b;
    logic [24:0] sdr_addr_b;

    logic        sel;
    logic        fill_m, sdr_req_m, busy_m, ur_m, to_m;
    logic [15:0] data_m;
    logic [24:0] sdr_addr_m;

    int          checks   = 0;
    int          failures = 0;
    int          pos      = -1;
    int          streams  = 0;
    int          ur_from  = 99;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sdram_fill_sequencer #(.ADDR_W(25), .START_LEVEL(8), .REQ_TIMEOUT(10)) u_dut_a (
        .clk(clk), .reset(reset), .cache_req(cache_req), .cache_addr(cache_addr),
        .cache_fill(cache_fill_a), .cache_data(cache_data_a), .sdr_req(sdr_req_a),
        .sdr_addr(sdr_addr_a), .sdr_ack(sdr_ack), .sdr_valid(sdr_valid),
        .sdr_data(sdr_data), .busy(busy_a), .underrun(underrun_a), .timeout(timeout_a)
    );

    sdram_fill_sequencer #(.ADDR_W(25), .START_LEVEL(2), .REQ_TIMEOUT(10)) u_dut_b (
        .clk(clk), .reset(reset), .cache_req(cache_req), .cache_addr(cache_addr),
        .cache_fill(cache_fill_b), .cache_data(cache_data_b), .sdr_req(sdr_req_b),
        .sdr_addr(sdr_addr_b), .sdr_ack(sdr_ack), .sdr_valid(sdr_valid),
        .sdr_data(sdr_data), .busy(busy_b), .underrun(underrun_b), .timeout(timeout_b)
    );

    assign fill_m     = sel ? cache_fill_b : cache_fill_a;
    assign data_m     = sel ? cache_data_b : cache_data_a;
    assign sdr_req_m  = sel ? sdr_req_b    : sdr_req_a;
    assign sdr_addr_m = sel ? sdr_addr_b   : sdr_addr_a;
    assign busy_m     = sel ? busy_b       : busy_a;
    assign ur_m       = sel ? underrun_b   : underrun_a;
    assign to_m       = sel ? timeout_b    : timeout_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Stream monitor: slot 0 begins on cache_fill, slots 1..7 follow on consecutive cycles.
    task automatic mon();
        logic [15:0] want;
        if (pos < 0) begin
            if (fill_m !== 1'b1) return;
            pos = 0;
        end else begin
            chk("fill_only_on_word0", fill_m, 0);
        end
        want = 16'hxxxx;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        chk($sformatf("stream_word%0d", pos), data_m, want);
        chk("busy_during_stream", busy_m, 1);
        chk("no_sdr_req_during_stream", sdr_req_m, 0);
        chk($sformatf("underrun_word%0d", pos), ur_m, (pos >= ur_from) ? 1 : 0);
        pos++;
        if (pos == 8) begin
            pos = -1;
            streams++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cache_req = 1'b0;
        sdr_ack   = 1'b0;
        sdr_valid = 1'b0;
        sdr_data  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pos   = -1;
        exp_q.delete();
    endtask

    task automatic request(input logic [24:0] addr, input logic hold);
        cache_req  = 1'b1;
        cache_addr = addr;
        tick();
        if (!hold) cache_req = 1'b0;
        chk("sdr_req_raised", sdr_req_m, 1);
        chk("sdr_addr_latched", sdr_addr_m, addr);
        chk("busy_raised", busy_m, 1);
    endtask

    task automatic ack_after(input int n);
        for (int i = 1; i < n; i++) begin
            tick();
            chk("sdr_req_held", sdr_req_m, 1);
        end
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        chk("sdr_req_cleared_after_ack", sdr_req_m, 0);
    endtask

    task automatic send_words(input logic [15:0] base, input int n, input int gap,
                              input logic push);
        for (int j = 0; j < n; j++) begin
            sdr_valid = 1'b1;
            sdr_data  = base + 16'(j);
            if (push) exp_q.push_back(base + 16'(j));
            tick();
            sdr_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (push) chk("busy_while_collecting", busy_m, 1);
            end
        end
    endtask

    task automatic wait_stream(input int snap, input string tag);
        for (int i = 0; i < 40 && streams == snap; i++) tick();
        chk(tag, streams - snap, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        sel        = 1'b0;
        cache_addr = '0;
        reset      = 1'b1;
        cache_req  = 1'b0;
        sdr_ack    = 1'b0;
        sdr_valid  = 1'b0;
        sdr_data   = '0;
        @(posedge clk);
        #1;
        chk("reset_cache_fill", fill_m, 0);
        chk("reset_cache_data", data_m, 0);
        chk("reset_sdr_req", sdr_req_m, 0);
        chk("reset_sdr_addr", sdr_addr_m, 0);
        chk("reset_busy", busy_m, 0);
        chk("reset_underrun", ur_m, 0);
        chk("reset_timeout", to_m, 0);
        reset = 1'b0;

        // 1: gapless burst, fill one cycle after the eighth word.
        do_reset();
        request(25'h000123, 1'b0);
        ack_after(3);
        snap = streams;
        send_words(16'hA000, 8, 0, 1'b1);
        chk("t1_fill_after_last_valid", cache_fill_a, 1);
        chk("t1_fill_data", cache_data_a, 16'hA000);
        wait_stream(snap, "t1_stream_complete");
        tick();
        chk("t1_busy_drops", busy_m, 0);
        chk("t1_no_timeout", to_m, 0);

        // 2: two idle cycles between words, stream still contiguous.
        do_reset();
        request(25'h000123, 1'b0);
        ack_after(3);
        snap = streams;
        send_words(16'hA000, 8, 2, 1'b1);
        wait_stream(snap, "t2_stream_complete");
        tick();
        chk("t2_busy_drops", busy_m, 0);
        chk("t2_no_underrun", ur_m, 0);

        // 3: START_LEVEL=2 with words every 3 cycles; from word 2 on the stream
        // is ahead of arrivals, so word 1 repeats and underrun sets.
        do_reset();
        sel     = 1'b1;
        ur_from = 2;
        request(25'h000040, 1'b0);
        ack_after(1);
        snap = streams;
        exp_q.push_back(16'hC000);
        for (int k = 1; k < 8; k++) exp_q.push_back(16'hC001);
        send_words(16'hC000, 8, 2, 1'b0);
        wait_stream(snap, "t3_stream_complete");
        chk("t3_underrun_sticky", ur_m, 1);
        sel     = 1'b0;
        ur_from = 99;

        // 4: reset after four words abandons the burst.
        do_reset();
        request(25'h000123, 1'b0);
        ack_after(2);
        send_words(16'hD000, 4, 0, 1'b1);
        chk("t4_busy_before_reset", busy_m, 1);
        reset = 1'b1;
        #1;
        chk("t4_reset_busy", busy_m, 0);
        chk("t4_reset_sdr_req", sdr_req_m, 0);
        chk("t4_reset_sdr_addr", sdr_addr_m, 0);
        chk("t4_reset_fill", fill_m, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pos   = -1;
        exp_q.delete();
        send_words(16'hD004, 4, 0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_late_words_ignored_busy", busy_m, 0);
        chk("t4_late_words_ignored_data", data_m, 0);
        request(25'h000200, 1'b0);
        ack_after(2);
        snap = streams;
        send_words(16'hE000, 8, 0, 1'b1);
        wait_stream(snap, "t4_clean_restart_stream");

        // 5: ack withheld 15 cycles; timeout flags at cycle 10, request stays up.
        do_reset();
        request(25'h000123, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("t5_timeout_c%0d", k), to_m, (k >= 10) ? 1 : 0);
            chk("t5_sdr_req_held", sdr_req_m, 1);
        end
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        chk("t5_sdr_req_cleared", sdr_req_m, 0);
        snap = streams;
        send_words(16'hF000, 8, 0, 1'b1);
        wait_stream(snap, "t5_stream_complete");
        chk("t5_timeout_sticky", to_m, 1);

        // 6: cache_req held through the stream chains a second burst.
        do_reset();
        request(25'h000123, 1'b1);
        ack_after(3);
        snap = streams;
        send_words(16'hA000, 8, 0, 1'b1);
        chk("t6_fill_first", cache_fill_a, 1);
        cache_addr = 25'h0ABCDE;
        for (int i = 0; i < 7; i++) tick();
        chk("t6_first_stream_done", streams - snap, 1);
        tick();
        chk("t6_second_sdr_req", sdr_req_m, 1);
        chk("t6_second_sdr_addr", sdr_addr_m, 25'h0ABCDE);
        chk("t6_busy_continues", busy_m, 1);
        cache_req = 1'b0;
        ack_after(2);
        snap = streams;
        send_words(16'hB000, 8, 0, 1'b1);
        wait_stream(snap, "t6_second_stream_complete");
        tick();
        chk("t6_busy_drops", busy_m, 0);
        chk("t6_no_third_req", sdr_req_m, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
